// File: rtl/oclib_pkg.sv
// Shared CSR bus types: request (address/wdata/read/write) and response (rdata/ready/error).
package oclib_pkg;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] wdata;
      logic        read;
      logic        write;
   } csr_32_s;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
      logic        error;
   } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_splitter.sv
// Routes one upstream CSR request to one of NumTargets downstream CSR targets by address,
// with decode-miss and timeout errors and a single-cycle upstream ready pulse.
module oclib_csr_splitter
   import oclib_pkg::*;
#(
   parameter int NumTargets    = 4,
   parameter int TargetShift   = 12,
   parameter int TimeoutCycles = 1024
) (
   input  logic                 clock,
   input  logic                 reset,
   input  csr_32_s              in,
   output csr_32_fb_s           inFb,
   output csr_32_s              out       [0:NumTargets-1],
   input  csr_32_fb_s           outFb     [0:NumTargets-1],
   output logic [0:NumTargets-1] outSelect
);

   typedef enum logic [1:0] {Idle, Busy, Respond} state_e;

   localparam int IdxW = (NumTargets > 1) ? $clog2(NumTargets) : 1;
   localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

   state_e                state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  write_q, write_d;
   logic                  error_q, error_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [0:NumTargets-1] sel_q, sel_d;

   logic [31:0]           req_idx;
   logic                  req_hit;
   logic [CntW-1:0]       cnt_inc;
   logic                  timeout;
   csr_32_fb_s            fb;

   assign req_idx = in.address >> TargetShift;
   assign req_hit = req_idx < 32'(NumTargets);
   assign fb      = outFb[idx_q];

   // Saturating count; the timeout fires in the Busy cycle in which the count reaches the limit.
   assign cnt_inc = (cnt_q == CntLimit) ? cnt_q : cnt_q + 1'b1;
   assign timeout = (TimeoutCycles != 0) && (cnt_inc == CntLimit);

   always_comb begin
      // NOTE: every signal is given its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      write_d = write_q;
      error_d = error_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;

      case (state_q)
         Idle: begin
            if (in.read || in.write) begin
               addr_d  = in.address;
               wdata_d = in.wdata;
               write_d = in.write;
               idx_d   = req_idx[IdxW-1:0];
               if (req_hit) begin
                  state_d                    = Busy;
                  cnt_d                      = '0;
                  sel_d                      = '0;
                  sel_d[req_idx[IdxW-1:0]]   = 1'b1;
               end else begin
                  state_d = Respond;
                  error_d = 1'b1;
                  rdata_d = '0;
               end
            end
         end

         Busy: begin
            if (fb.ready) begin
               state_d = Respond;
               sel_d   = '0;
               rdata_d = write_q ? '0 : fb.rdata;
               error_d = fb.error;
            end else if (timeout) begin
               state_d = Respond;
               sel_d   = '0;
               rdata_d = '0;
               error_d = 1'b1;
               cnt_d   = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         Respond: begin
            state_d = Idle;
            rdata_d = '0;
            error_d = 1'b0;
         end

         default: state_d = Idle;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= Idle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         write_q <= 1'b0;
         error_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
         error_q <= error_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

   for (genvar i = 0; i < NumTargets; i++) begin : g_out
      assign out[i] = sel_q[i] ? csr_32_s'{address: addr_q, wdata: wdata_q,
                                           read: ~write_q, write: write_q}
                               : csr_32_s'('0);
   end

   assign outSelect = sel_q;
   assign inFb      = csr_32_fb_s'{rdata: rdata_q, ready: (state_q == Respond), error: error_q};

endmodule
